// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: fetches one four-word cache line from main memory after a miss,
// hands it to the cache with a line-write request, then pulses a flag clear.
// Optional build macro FILL_TIMEOUT_EN adds a per-word memory wait limit (TIMEOUT
// cycles) that aborts the fill through ERR with an err pulse.
//
// Memory handshake: mem_rd is held high for the whole RD state while mem_adr shows
// the word wanted; a word is transferred on every rising edge where mem_rd=1 and
// mem_ready=1, and mem_ready is ignored whenever mem_rd=0.
//
// The IDLE cycle that sees need only latches the miss address; RD is entered on the
// following edge, so the first word can be captured two edges after need is sampled.
module cache_fill_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        need,
  input  logic [14:0] Adr,
  input  logic        writed,
  output logic        mem_rd,
  output logic [14:0] mem_adr,
  input  logic [31:0] mem_data,
  input  logic        mem_ready,
  output logic [31:0] R1,
  output logic [31:0] R2,
  output logic [31:0] R3,
  output logic [31:0] R4,
  output logic        WE,
  output logic        forc,
  output logic        busy,
  output logic        err,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    CLR  = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t      state;
  logic [14:0] base;
  logic [1:0]  cnt;
  logic        pend;

  // Elaboration-time guard on the wait limit range.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("cache_fill_ctrl: TIMEOUT must be in 1..255");
  end

`ifdef FILL_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt;
`endif

  assign fsm_state = state;

  // Fill sequencer: state, line buffer and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      base    <= '0;
      cnt     <= '0;
      pend    <= 1'b0;
      mem_rd  <= 1'b0;
      mem_adr <= '0;
      R1      <= '0;
      R2      <= '0;
      R3      <= '0;
      R4      <= '0;
      WE      <= 1'b0;
      forc    <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
`ifdef FILL_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pend) begin
            pend    <= 1'b0;
            state   <= RD;
            mem_rd  <= 1'b1;
            mem_adr <= base;
            busy    <= 1'b1;
`ifdef FILL_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end else if (need) begin
            base <= Adr;
            cnt  <= '0;
            pend <= 1'b1;
          end
        end
        RD: begin
          if (mem_ready) begin
            case (cnt)
              2'd0:    R1 <= mem_data;
              2'd1:    R2 <= mem_data;
              2'd2:    R3 <= mem_data;
              default: R4 <= mem_data;
            endcase
            cnt <= cnt + 2'd1;
`ifdef FILL_TIMEOUT_EN
            wait_cnt <= '0;
`endif
            if (cnt == 2'd3) begin
              state   <= WR;
              mem_rd  <= 1'b0;
              mem_adr <= '0;
              WE      <= 1'b1;
            end else begin
              // 15-bit sum wraps 0x7FFF -> 0x0000 across tag and index.
              mem_adr <= base + 15'(cnt) + 15'd1;
            end
          end
`ifdef FILL_TIMEOUT_EN
          else if (wait_cnt == WAIT_LAST) begin
            state   <= ERR;
            mem_rd  <= 1'b0;
            mem_adr <= '0;
            err     <= 1'b1;
            forc    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        WR: begin
          if (writed) begin
            state <= CLR;
            WE    <= 1'b0;
            forc  <= 1'b1;
          end
        end
        CLR: begin
          state <= IDLE;
          forc  <= 1'b0;
          busy  <= 1'b0;
        end
        ERR: begin
          state <= IDLE;
          forc  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          mem_rd <= 1'b0;
          WE     <= 1'b0;
          forc   <= 1'b0;
          busy   <= 1'b0;
          err    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl: directed fills of cache_fill_ctrl with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_cache_fill_ctrl;

`ifdef FILL_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk;
  logic        rst_n;
  logic        need;
  logic [14:0] Adr;
  logic        writed;
  logic        mem_rd;
  logic [14:0] mem_adr;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic [31:0] R1, R2, R3, R4;
  logic        WE, forc, busy, err;
  logic [2:0]  fsm_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  cache_fill_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .need(need), .Adr(Adr), .writed(writed),
    .mem_rd(mem_rd), .mem_adr(mem_adr), .mem_data(mem_data), .mem_ready(mem_ready),
    .R1(R1), .R2(R2), .R3(R3), .R4(R4),
    .WE(WE), .forc(forc), .busy(busy), .err(err), .fsm_state(fsm_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_rd"},   mem_rd,  0);
    check({tag, "_adr"},  mem_adr, 0);
    check({tag, "_we"},   WE,      0);
    check({tag, "_forc"}, forc,    0);
    check({tag, "_busy"}, busy,    0);
    check({tag, "_err"},  err,     0);
    check({tag, "_r1"},   R1,      0);
    check({tag, "_r2"},   R2,      0);
    check({tag, "_st"},   fsm_state, 0);
  endtask

  // One full fill: called and returns at a falling edge.
  task automatic run_fill(input logic [14:0] adr, input logic [31:0] d0, input int gap,
                          input int wr_gap, input bit pre, input bit chain,
                          input logic [14:0] nxt);
    logic [14:0] ea;
    logic [31:0] w0, w1, w2, w3;
    if (!pre) begin
      need = 1'b1;
      Adr  = adr;
    end
    @(negedge clk);
    need = 1'b0;
    check("start_busy", busy, 0);
    check("start_rd", mem_rd, 0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      ea = adr + 15'(k);
      for (int g = 0; g < gap; g++) begin
        check("wait_rd", mem_rd, 1);
        check("wait_adr", mem_adr, ea);
        check("wait_err", err, 0);
        mem_ready = 1'b0;
        @(negedge clk);
      end
      check("rd_strobe", mem_rd, 1);
      check("rd_adr", mem_adr, ea);
      check("rd_busy", busy, 1);
      mem_ready = 1'b1;
      mem_data  = d0 + 32'(k);
      exp_q.push_back(d0 + 32'(k));
      @(negedge clk);
    end
    mem_ready = 1'b0;
    mem_data  = '0;
    need      = 1'b1;
    w0 = exp_q.pop_front();
    w1 = exp_q.pop_front();
    w2 = exp_q.pop_front();
    w3 = exp_q.pop_front();
    check("wr_we", WE, 1);
    check("wr_rd", mem_rd, 0);
    check("wr_forc", forc, 0);
    check("r1", R1, w0);
    check("r2", R2, w1);
    check("r3", R3, w2);
    check("r4", R4, w3);
    for (int i = 0; i < wr_gap; i++) begin
      @(negedge clk);
      check("wr_hold_we", WE, 1);
      check("wr_hold_forc", forc, 0);
      check("wr_hold_r1", R1, w0);
      check("wr_hold_r4", R4, w3);
    end
    writed = 1'b1;
    @(negedge clk);
    writed = 1'b0;
    check("clr_forc", forc, 1);
    check("clr_we", WE, 0);
    check("clr_busy", busy, 1);
    @(negedge clk);
    check("idle_forc", forc, 0);
    check("idle_busy", busy, 0);
    check("idle_st", fsm_state, 0);
    check("idle_r1", R1, w0);
    check("idle_r4", R4, w3);
    if (chain) begin
      need = 1'b1;
      Adr  = nxt;
    end else begin
      need = 1'b0;
    end
  endtask

  // Stimulus and final report
  initial begin
    rst_n = 1'b0; need = 1'b0; Adr = '0; writed = 1'b0;
    mem_data = '0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_fill(15'h1234, 32'h0000_00A0, 0, 0, 1'b0, 1'b0, 15'h0);
    run_fill(15'h7FFE, 32'h1000_0000, 0, 0, 1'b0, 1'b0, 15'h0);
    run_fill(15'h0420, 32'h0000_00B0, 3, 0, 1'b0, 1'b0, 15'h0);
    run_fill(15'h0100, 32'h0000_00C0, 0, 10, 1'b0, 1'b1, 15'h2222);
    run_fill(15'h2222, 32'h0000_00D0, 0, 0, 1'b1, 1'b0, 15'h0);
`ifndef FILL_TIMEOUT_EN
    run_fill(15'h0555, 32'h0000_00E0, 300, 0, 1'b0, 1'b0, 15'h0);
`endif

    // Reset in the middle of a fill, after the second word.
    need = 1'b1; Adr = 15'h3000;
    @(negedge clk);
    need = 1'b0;
    @(negedge clk);
    mem_ready = 1'b1; mem_data = 32'h11;
    @(negedge clk);
    mem_data = 32'h22;
    @(negedge clk);
    mem_ready = 1'b0;
    check("mid_r2", R2, 32'h22);
    check("mid_adr", mem_adr, 15'h3002);
    rst_n = 1'b0;
    #1;
    check_idle_zero("async_rst");
    @(negedge clk);
    check_idle_zero("held_rst");
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_we", WE, 0);
    check("post_rst_forc", forc, 0);
    run_fill(15'h4010, 32'h0000_00F0, 0, 0, 1'b0, 1'b0, 15'h0);

`ifdef FILL_TIMEOUT_EN
    // Memory never answers: abort after TIMEOUT RD cycles.
    need = 1'b1; Adr = 15'h0600;
    @(negedge clk);
    need = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("to_wait_err", err, 0);
      check("to_wait_rd", mem_rd, 1);
      @(negedge clk);
    end
    check("to_err", err, 1);
    check("to_forc", forc, 1);
    check("to_we", WE, 0);
    check("to_rd", mem_rd, 0);
    @(negedge clk);
    check("to_err_end", err, 0);
    check("to_forc_end", forc, 0);
    check("to_busy_end", busy, 0);
    check("to_we_end", WE, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
